// File: rtl/nios2_debug_slave_cmd_queue_if.sv
// nios2_debug_slave_cmd_queue_if: command release handshake between the debug slave queue and OCI logic
interface nios2_debug_slave_cmd_queue_if #(
    parameter int SR_W = 38,
    parameter int IR_W = 2,
    localparam int NUM_CMDS = 2**IR_W
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [SR_W-1:0]     jdo;
    logic [IR_W-1:0]     jdo_ir;
    logic [NUM_CMDS-1:0] take_action;
    logic [NUM_CMDS-1:0] take_no_action;
    modport master (output cmd_valid, jdo, jdo_ir, take_action, take_no_action, input cmd_ready);
    modport slave  (input cmd_valid, jdo, jdo_ir, take_action, take_no_action, output cmd_ready);
endinterface

// File: rtl/nios2_debug_slave_cmd_queue.sv
// nios2_debug_slave_cmd_queue: sysclk-side JTAG debug slave, syncs update strobes and queues captured commands
module nios2_debug_slave_cmd_queue #(
    parameter int SR_W         = 38,
    parameter int IR_W         = 2,
    parameter int ACTION_BIT   = 34,
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter bit FLUSH_ON_UIR = 1'b1,
    localparam int NUM_CMDS    = 2**IR_W,
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = $clog2(DEPTH+1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            vs_udr,
    input  logic            vs_uir,
    input  logic [IR_W-1:0] ir_in,
    input  logic [SR_W-1:0] sr,
    input  logic            ovf_clr,
    nios2_debug_slave_cmd_queue_if.master cmd,
    output logic [IR_W-1:0] ir_shadow,
    output logic [CW-1:0]   fifo_count,
    output logic            overflow
);
    logic [SYNC_STAGES-1:0] udr_sync, uir_sync;
    logic                   udr_prev, uir_prev, udr_rise, uir_rise;
    logic                   flush, full, pop, push;
    logic [IR_W+SR_W-1:0]   mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [SR_W-1:0]        head_sr;
    logic [IR_W-1:0]        head_ir;
    logic [NUM_CMDS-1:0]    onehot;
    logic [CW-1:0]          next_count;

    assign udr_rise = udr_sync[SYNC_STAGES-1] & ~udr_prev;
    assign uir_rise = uir_sync[SYNC_STAGES-1] & ~uir_prev;
    assign flush    = FLUSH_ON_UIR & uir_rise;
    // A flush empties the queue first, so a coincident capture always finds room
    assign full     = (fifo_count == CW'(DEPTH)) & ~flush;
    assign pop      = cmd.cmd_valid & cmd.cmd_ready & ~flush;
    assign push     = udr_rise & (~full | pop);
    assign {head_ir, head_sr} = mem[rd_ptr];
    assign onehot   = NUM_CMDS'(1) << head_ir;
    assign next_count = flush ? CW'(push) : fifo_count + CW'(push) - CW'(pop);

    // Storage needs no reset: pointers and count define what is live
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= {ir_in, sr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            udr_sync           <= '0;
            uir_sync           <= '0;
            udr_prev           <= 1'b0;
            uir_prev           <= 1'b0;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            fifo_count         <= '0;
            cmd.cmd_valid      <= 1'b0;
            cmd.jdo            <= '0;
            cmd.jdo_ir         <= '0;
            cmd.take_action    <= '0;
            cmd.take_no_action <= '0;
            ir_shadow          <= '0;
            overflow           <= 1'b0;
        end else begin
            udr_sync           <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
            uir_sync           <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
            udr_prev           <= udr_sync[SYNC_STAGES-1];
            uir_prev           <= uir_sync[SYNC_STAGES-1];
            if (uir_rise) ir_shadow <= ir_in;
            wr_ptr             <= wr_ptr + AW'(push);
            rd_ptr             <= flush ? wr_ptr : rd_ptr + AW'(pop);
            fifo_count         <= next_count;
            cmd.cmd_valid      <= next_count != '0;
            overflow           <= (udr_rise & ~push) | (overflow & ~ovf_clr);
            if (pop) begin
                cmd.jdo        <= head_sr;
                cmd.jdo_ir     <= head_ir;
            end
            cmd.take_action    <= (pop & head_sr[ACTION_BIT]) ? onehot : '0;
            cmd.take_no_action <= (pop & ~head_sr[ACTION_BIT]) ? onehot : '0;
        end
    end
endmodule

// File: tb/tb_nios2_debug_slave_cmd_queue.sv
// tb_nios2_debug_slave_cmd_queue: directed-vector bench for the debug slave command queue
module tb_nios2_debug_slave_cmd_queue;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vs_udr = 1'b0;
    logic        vs_uir = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        ovf_clr = 1'b0;
    logic [1:0]  ir_shadow;
    logic [2:0]  fifo_count;
    logic        overflow;
    int          vectors = 0;
    int          miscompares = 0;

    nios2_debug_slave_cmd_queue_if #(.SR_W(38), .IR_W(2)) cmd_if ();

    nios2_debug_slave_cmd_queue dut (
        .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .ir_in(ir_in), .sr(sr), .ovf_clr(ovf_clr), .cmd(cmd_if.master),
        .ir_shadow(ir_shadow), .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Write lands at the third edge; returns just after the fourth edge
    task automatic send(input logic [1:0] ir, input logic [37:0] d);
        ir_in = ir;
        sr = d;
        vs_udr = 1'b1;
        tick(2);
        vs_udr = 1'b0;
        tick(2);
    endtask

    initial begin
        cmd_if.cmd_ready = 1'b0;
        tick(2);
        chk("rst_valid", 64'(cmd_if.cmd_valid), 0);
        chk("rst_count", 64'(fifo_count), 0);
        chk("rst_jdo", 64'(cmd_if.jdo), 0);
        chk("rst_act", 64'(cmd_if.take_action), 0);
        chk("rst_noact", 64'(cmd_if.take_no_action), 0);
        chk("rst_ovf", 64'(overflow), 0);
        reset_n = 1'b1;
        tick(2);

        // 1: action command, latency 4 edges
        ir_in = 2'd2;
        sr = 38'h04_0000_1234;
        vs_udr = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        tick(2);
        chk("t1_e2_count", 64'(fifo_count), 0);
        chk("t1_e2_valid", 64'(cmd_if.cmd_valid), 0);
        vs_udr = 1'b0;
        tick(1);
        chk("t1_e3_valid", 64'(cmd_if.cmd_valid), 1);
        chk("t1_e3_count", 64'(fifo_count), 1);
        chk("t1_e3_act", 64'(cmd_if.take_action), 0);
        tick(1);
        chk("t1_jdo", 64'(cmd_if.jdo), 64'h04_0000_1234);
        chk("t1_jdo_ir", 64'(cmd_if.jdo_ir), 2);
        chk("t1_act", 64'(cmd_if.take_action), 4'b0100);
        chk("t1_noact", 64'(cmd_if.take_no_action), 0);
        chk("t1_count", 64'(fifo_count), 0);
        chk("t1_valid", 64'(cmd_if.cmd_valid), 0);
        tick(1);
        chk("t1_act_end", 64'(cmd_if.take_action), 0);
        chk("t1_jdo_hold", 64'(cmd_if.jdo), 64'h04_0000_1234);

        // 2: no-action command
        send(2'd1, 38'h00_0000_0055);
        chk("t2_noact", 64'(cmd_if.take_no_action), 4'b0010);
        chk("t2_act", 64'(cmd_if.take_action), 0);
        chk("t2_jdo", 64'(cmd_if.jdo), 64'h55);
        chk("t2_jdo_ir", 64'(cmd_if.jdo_ir), 1);
        tick(1);
        chk("t2_noact_end", 64'(cmd_if.take_no_action), 0);

        // 3: overflow on fifth command, then in-order drain
        cmd_if.cmd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(2'd0, 38'(i));
        chk("t3_count", 64'(fifo_count), 4);
        chk("t3_ovf", 64'(overflow), 1);
        chk("t3_valid", 64'(cmd_if.cmd_valid), 1);
        cmd_if.cmd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            chk("t3_drain_jdo", 64'(cmd_if.jdo), 64'(i));
            chk("t3_drain_noact", 64'(cmd_if.take_no_action), 4'b0001);
            chk("t3_drain_count", 64'(fifo_count), 64'(4 - i));
        end
        chk("t3_empty_valid", 64'(cmd_if.cmd_valid), 0);
        tick(1);
        chk("t3_noact_end", 64'(cmd_if.take_no_action), 0);
        chk("t3_jdo_hold", 64'(cmd_if.jdo), 4);
        chk("t3_ovf_sticky", 64'(overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 64'(overflow), 0);

        // 4: IR update flushes queue, no pop in that cycle
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'd1, 38'(16 + i));
        chk("t4_count", 64'(fifo_count), 3);
        ir_in = 2'd3;
        vs_uir = 1'b1;
        tick(2);
        vs_uir = 1'b0;
        chk("t4_pre_count", 64'(fifo_count), 3);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        chk("t4_count0", 64'(fifo_count), 0);
        chk("t4_valid", 64'(cmd_if.cmd_valid), 0);
        chk("t4_shadow", 64'(ir_shadow), 3);
        chk("t4_act", 64'(cmd_if.take_action), 0);
        chk("t4_noact", 64'(cmd_if.take_no_action), 0);
        chk("t4_jdo_hold", 64'(cmd_if.jdo), 4);
        tick(2);

        // 5a: coincident IR and DR update with two queued
        cmd_if.cmd_ready = 1'b0;
        send(2'd0, 38'd32);
        send(2'd0, 38'd33);
        chk("t5a_pre_count", 64'(fifo_count), 2);
        ir_in = 2'd2;
        sr = 38'h03_0000_0077;
        vs_udr = 1'b1;
        vs_uir = 1'b1;
        tick(2);
        vs_udr = 1'b0;
        vs_uir = 1'b0;
        tick(1);
        chk("t5a_count", 64'(fifo_count), 1);
        chk("t5a_valid", 64'(cmd_if.cmd_valid), 1);
        chk("t5a_shadow", 64'(ir_shadow), 2);
        tick(1);
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        chk("t5a_jdo", 64'(cmd_if.jdo), 64'h03_0000_0077);
        chk("t5a_noact", 64'(cmd_if.take_no_action), 4'b0100);
        chk("t5a_count0", 64'(fifo_count), 0);

        // 5b: push while full with a coincident pop
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(2'd1, 38'(49 + i));
        chk("t5b_full", 64'(fifo_count), 4);
        ir_in = 2'd3;
        sr = 38'h04_0000_0035;
        vs_udr = 1'b1;
        tick(2);
        vs_udr = 1'b0;
        cmd_if.cmd_ready = 1'b1;
        tick(1);
        chk("t5b_count", 64'(fifo_count), 4);
        chk("t5b_ovf", 64'(overflow), 0);
        chk("t5b_jdo", 64'(cmd_if.jdo), 49);
        chk("t5b_noact", 64'(cmd_if.take_no_action), 4'b0010);
        tick(3);
        chk("t5b_jdo3", 64'(cmd_if.jdo), 52);
        tick(1);
        chk("t5b_jdo_new", 64'(cmd_if.jdo), 64'h04_0000_0035);
        chk("t5b_act_new", 64'(cmd_if.take_action), 4'b1000);
        chk("t5b_count0", 64'(fifo_count), 0);

        // 6: async reset mid-queue
        cmd_if.cmd_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(2'd1, 38'h04_0000_0040 + 38'(i));
        chk("t6_count", 64'(fifo_count), 3);
        #3 reset_n = 1'b0;
        #1;
        chk("t6_rst_count", 64'(fifo_count), 0);
        chk("t6_rst_valid", 64'(cmd_if.cmd_valid), 0);
        chk("t6_rst_jdo", 64'(cmd_if.jdo), 0);
        chk("t6_rst_jdo_ir", 64'(cmd_if.jdo_ir), 0);
        chk("t6_rst_shadow", 64'(ir_shadow), 0);
        tick(2);
        reset_n = 1'b1;
        cmd_if.cmd_ready = 1'b1;
        tick(3);
        chk("t6_post_act", 64'(cmd_if.take_action), 0);
        chk("t6_post_noact", 64'(cmd_if.take_no_action), 0);
        chk("t6_post_count", 64'(fifo_count), 0);
        send(2'd3, 38'h04_0000_00AA);
        chk("t6_new_act", 64'(cmd_if.take_action), 4'b1000);
        chk("t6_new_jdo", 64'(cmd_if.jdo), 64'h04_0000_00AA);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
